// File: rtl/sprite_layer_gen_pkg.sv
// Shared widths, scan limits and per-sprite configuration record for the sprite layer.
package sprite_pkg;
    localparam int X_W     = 13;
    localparam int Y_W     = 10;
    localparam int FRAME_W = 3;
    localparam int H_LIMIT = 575;
    localparam int V_LIMIT = 239;
    // Wide enough that world/sprite differences never wrap for any input combination.
    localparam int CALC_W  = 16;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic               enable;
        logic               flip;
        logic               anim_en;
        logic [FRAME_W-1:0] base_frame;
        logic [FRAME_W-1:0] anim_len;
    } sprite_cfg_t;
endpackage

// File: rtl/sprite_layer_gen_anim_phase.sv
// Per-sprite animation phase counter; steps on anim ticks and wraps at the cycle length.
module sprite_anim_phase
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               tick,
    input  logic               anim_en,
    input  logic [FRAME_W-1:0] anim_len,
    output logic [FRAME_W-1:0] phase
);
    logic [FRAME_W-1:0] phase_reg;
    logic [FRAME_W:0]   len_eff;
    logic [FRAME_W:0]   phase_inc;

    assign len_eff   = (anim_len == '0) ? (FRAME_W+1)'(1) : {1'b0, anim_len};
    assign phase_inc = {1'b0, phase_reg} + 1'b1;

    // Using >= also recovers a phase left beyond a shortened cycle.
    always_ff @(posedge clk) begin
        if (srst || !anim_en) begin
            phase_reg <= '0;
        end else if (tick) begin
            phase_reg <= (phase_inc >= len_eff) ? '0 : phase_inc[FRAME_W-1:0];
        end
    end

    assign phase = phase_reg;
endmodule

// File: rtl/sprite_layer_gen.sv
// Multi-sprite ROM address generator: per-sprite hit test (stage 1), priority pick and address (stage 2).
module sprite_layer_gen
    import sprite_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int HEIGHT      = 32,
    parameter int NUM_FRAMES  = 8,
    parameter int NUM_SPRITES = 4,
    parameter int FRAME_HOLD  = 6,
    parameter int H_LIMIT     = sprite_pkg::H_LIMIT,
    parameter int V_LIMIT     = sprite_pkg::V_LIMIT,
    localparam int ADDR_W     = $clog2(WIDTH*HEIGHT*NUM_FRAMES),
    localparam int ID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                         pixel_clk_in,
    input  logic                         rst_in,
    input  logic [10:0]                  hcount_in,
    input  logic [9:0]                   vcount_in,
    input  logic [11:0]                  offset_background,
    input  logic [X_W*NUM_SPRITES-1:0]   x_in,
    input  logic [Y_W*NUM_SPRITES-1:0]   y_in,
    input  logic [NUM_SPRITES-1:0]       enable_in,
    input  logic [NUM_SPRITES-1:0]       flip_in,
    input  logic [NUM_SPRITES-1:0]       anim_en_in,
    input  logic [FRAME_W*NUM_SPRITES-1:0] base_frame_in,
    input  logic [FRAME_W*NUM_SPRITES-1:0] anim_len_in,
    output logic [ADDR_W-1:0]            image_addr,
    output logic [ID_W-1:0]              sprite_id,
    output logic                         in_sprite
);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic signed [CALC_W-1:0] ZERO_S = '0;
    localparam logic signed [CALC_W-1:0] W_S    = CALC_W'(WIDTH);
    localparam logic signed [CALC_W-1:0] H_S    = CALC_W'(HEIGHT);
    localparam logic signed [CALC_W-1:0] HALF_W = CALC_W'(WIDTH/2);
    localparam logic signed [CALC_W-1:0] HALF_H = CALC_W'(HEIGHT/2);
    localparam logic [COL_W-1:0]         COL_MAX = COL_W'(WIDTH-1);

    sprite_cfg_t cfg [NUM_SPRITES];

    logic               hit_c  [NUM_SPRITES];
    logic [COL_W-1:0]   col_c  [NUM_SPRITES];
    logic [ROW_W-1:0]   row_c  [NUM_SPRITES];
    logic [FRAME_W-1:0] phase  [NUM_SPRITES];

    logic               hit_reg  [NUM_SPRITES];
    logic [COL_W-1:0]   col_reg  [NUM_SPRITES];
    logic [ROW_W-1:0]   row_reg  [NUM_SPRITES];
    logic [FRAME_W-1:0] base_reg [NUM_SPRITES];

    logic signed [CALC_W-1:0] world;
    logic signed [CALC_W-1:0] scan_row;
    logic                     active;

    logic              fs_raw;
    logic              fs_prev_reg;
    logic              frame_start;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              anim_tick;

    assign world    = signed'(CALC_W'(hcount_in)) + signed'(CALC_W'(offset_background));
    assign scan_row = signed'(CALC_W'(vcount_in));
    assign active   = (hcount_in <= 11'(H_LIMIT)) && (vcount_in <= 10'(V_LIMIT));

    // Edge-detect the top-left pixel so a stalled scan at (0,0) counts once.
    assign fs_raw      = (hcount_in == '0) && (vcount_in == '0);
    assign frame_start = fs_raw && !fs_prev_reg;
    assign anim_tick   = frame_start && (hold_cnt_reg == HOLD_W'(FRAME_HOLD-1));

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            fs_prev_reg  <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            fs_prev_reg <= fs_raw;
            if (frame_start) begin
                hold_cnt_reg <= (hold_cnt_reg == HOLD_W'(FRAME_HOLD-1)) ? '0 : hold_cnt_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
        logic signed [CALC_W-1:0] left;
        logic signed [CALC_W-1:0] top;
        logic signed [CALC_W-1:0] col;
        logic signed [CALC_W-1:0] row;
        logic [COL_W-1:0]         col_low;

        assign cfg[gi] = '{
            x:          x_in[gi*X_W +: X_W],
            y:          y_in[gi*Y_W +: Y_W],
            enable:     enable_in[gi],
            flip:       flip_in[gi],
            anim_en:    anim_en_in[gi],
            base_frame: base_frame_in[gi*FRAME_W +: FRAME_W],
            anim_len:   anim_len_in[gi*FRAME_W +: FRAME_W]
        };

        assign left    = signed'(CALC_W'(cfg[gi].x)) - HALF_W;
        assign top     = signed'(CALC_W'(cfg[gi].y)) - HALF_H;
        assign col     = world - left;
        assign row     = scan_row - top;
        assign col_low = col[COL_W-1:0];

        assign hit_c[gi] = cfg[gi].enable && active
                        && (col >= ZERO_S) && (col < W_S)
                        && (row >= ZERO_S) && (row < H_S);
        assign col_c[gi] = cfg[gi].flip ? (COL_MAX - col_low) : col_low;
        assign row_c[gi] = row[ROW_W-1:0];

        sprite_anim_phase u_phase (
            .clk      (pixel_clk_in),
            .srst     (rst_in),
            .tick     (anim_tick),
            .anim_en  (cfg[gi].anim_en),
            .anim_len (cfg[gi].anim_len),
            .phase    (phase[gi])
        );
    end

    always_ff @(posedge pixel_clk_in) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (rst_in) begin
                hit_reg[i]  <= 1'b0;
                col_reg[i]  <= '0;
                row_reg[i]  <= '0;
                base_reg[i] <= '0;
            end else begin
                hit_reg[i]  <= hit_c[i];
                col_reg[i]  <= col_c[i];
                row_reg[i]  <= row_c[i];
                base_reg[i] <= cfg[i].base_frame;
            end
        end
    end

    logic               sel_hit;
    logic [ID_W-1:0]    sel_id;
    logic [COL_W-1:0]   sel_col;
    logic [ROW_W-1:0]   sel_row;
    logic [FRAME_W-1:0] sel_frame;
    logic [ADDR_W-1:0]  sel_addr;

    // Scan from the lowest priority upwards so the lowest-index hit is written last.
    always_comb begin
        sel_hit   = 1'b0;
        sel_id    = '0;
        sel_col   = '0;
        sel_row   = '0;
        sel_frame = '0;
        for (int i = NUM_SPRITES-1; i >= 0; i--) begin
            if (hit_reg[i]) begin
                sel_hit   = 1'b1;
                sel_id    = ID_W'(i);
                sel_col   = col_reg[i];
                sel_row   = row_reg[i];
                sel_frame = base_reg[i] + phase[i];
            end
        end
        // Power-of-2 geometry: frame*W*H + row*W + col is a plain concatenation.
        sel_addr = ADDR_W'({sel_frame, sel_row, sel_col});
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            image_addr <= '0;
            sprite_id  <= '0;
            in_sprite  <= 1'b0;
        end else begin
            image_addr <= sel_hit ? sel_addr : '0;
            sprite_id  <= sel_id;
            in_sprite  <= sel_hit;
        end
    end
endmodule

// File: tb/tb_sprite_layer_gen.sv
// Directed bench for sprite_layer_gen: geometry, flip, priority, edges, animation and reset.
module tb_sprite_layer_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = 11'd200;
    logic [9:0]  vcount = 10'd200;
    logic [11:0] offset = '0;
    logic [51:0] x_in = '0;
    logic [39:0] y_in = '0;
    logic [3:0]  enable_in = '0;
    logic [3:0]  flip_in = '0;
    logic [3:0]  anim_en_in = '0;
    logic [11:0] base_frame_in = '0;
    logic [11:0] anim_len_in = '0;
    logic [11:0] image_addr;
    logic [1:0]  sprite_id;
    logic        in_sprite;

    int tests = 0;
    int fails = 0;

    sprite_layer_gen dut (
        .pixel_clk_in      (clk),
        .rst_in            (rst),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .offset_background (offset),
        .x_in              (x_in),
        .y_in              (y_in),
        .enable_in         (enable_in),
        .flip_in           (flip_in),
        .anim_en_in        (anim_en_in),
        .base_frame_in     (base_frame_in),
        .anim_len_in       (anim_len_in),
        .image_addr        (image_addr),
        .sprite_id         (sprite_id),
        .in_sprite         (in_sprite)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sprite(input int i, input int x, input int y, input bit en,
                              input bit flip, input bit anim, input int base, input int len);
        x_in[i*13 +: 13]         = 13'(x);
        y_in[i*10 +: 10]         = 10'(y);
        enable_in[i]             = en;
        flip_in[i]               = flip;
        anim_en_in[i]            = anim;
        base_frame_in[i*3 +: 3]  = 3'(base);
        anim_len_in[i*3 +: 3]    = 3'(len);
    endtask

    task automatic check(input string tag, input logic exp_in, input logic [11:0] exp_addr,
                         input logic [1:0] exp_id);
        tests++;
        assert ({in_sprite, sprite_id, image_addr} === {exp_in, exp_id, exp_addr})
        else begin
            fails++;
            $error("FAIL %s: got in=%0b id=%0d addr=%0d, expected in=%0b id=%0d addr=%0d",
                   tag, in_sprite, sprite_id, image_addr, exp_in, exp_id, exp_addr);
        end
        $display("[TB] %s h=%0d v=%0d -> in=%0b id=%0d addr=%0d",
                 tag, hcount, vcount, in_sprite, sprite_id, image_addr);
    endtask

    task automatic pix(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        cyc(2);
    endtask

    // Drive the top-left pixel for n cycles, then return to an in-sprite pixel.
    task automatic frame_pulse(input int n);
        hcount = '0;
        vcount = '0;
        cyc(n);
        hcount = 11'd93;
        vcount = 10'd35;
        cyc(1);
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) frame_pulse(1);
    endtask

    initial begin
        cyc(3);
        check("reset", 1'b0, 12'd0, 2'd0);
        rst = 1'b0;

        // Basic geometry: x=100,y=50 -> left 92, top 34, base frame 2.
        set_sprite(0, 100, 50, 1, 0, 0, 2, 1);
        pix(92, 34);   check("topleft", 1'b1, 12'd1024, 2'd0);
        pix(107, 65);  check("botright", 1'b1, 12'd1535, 2'd0);
        pix(108, 65);  check("right_miss", 1'b0, 12'd0, 2'd0);

        set_sprite(0, 100, 50, 1, 1, 0, 2, 1);
        pix(92, 34);   check("flip_left", 1'b1, 12'd1039, 2'd0);
        pix(107, 34);  check("flip_right", 1'b1, 12'd1024, 2'd0);

        set_sprite(0, 100, 50, 1, 0, 0, 2, 1);
        set_sprite(1, 100, 50, 1, 0, 0, 5, 1);
        pix(100, 40);  check("prio_s0", 1'b1, 12'd1128, 2'd0);
        enable_in[0] = 1'b0;
        pix(100, 40);  check("prio_s1", 1'b1, 12'd2664, 2'd1);

        // Signed left edge, scroll offset and active-area limits.
        set_sprite(1, 0, 0, 0, 0, 0, 0, 1);
        set_sprite(0, 3, 50, 1, 0, 0, 2, 1);
        pix(0, 40);    check("neg_left_hit", 1'b1, 12'd1125, 2'd0);
        pix(11, 40);   check("neg_left_miss", 1'b0, 12'd0, 2'd0);
        offset = 12'd200;
        set_sprite(0, 210, 50, 1, 0, 0, 2, 1);
        pix(2, 40);    check("offset_hit", 1'b1, 12'd1120, 2'd0);
        offset = 12'd0;
        set_sprite(0, 576, 50, 1, 0, 0, 2, 1);
        pix(575, 40);  check("hlimit_in", 1'b1, 12'd1127, 2'd0);
        pix(576, 40);  check("hlimit_out", 1'b0, 12'd0, 2'd0);
        set_sprite(0, 100, 240, 1, 0, 0, 2, 1);
        pix(100, 239); check("vlimit_in", 1'b1, 12'd1272, 2'd0);
        pix(100, 240); check("vlimit_out", 1'b0, 12'd0, 2'd0);

        // Animation: base 6, len 4; pixel (93,35) is col 1,row 1 -> frame*512 + 17.
        set_sprite(0, 100, 50, 1, 0, 1, 6, 4);
        hcount = 11'd93;
        vcount = 10'd35;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("anim_f6", 1'b1, 12'd3089, 2'd0);
        frame_pulse(3);
        pulses(4);
        cyc(1);        check("anim_hold_f6", 1'b1, 12'd3089, 2'd0);
        pulses(1);
        cyc(1);        check("anim_f7", 1'b1, 12'd3601, 2'd0);
        pulses(5);
        cyc(1);        check("anim_hold_f7", 1'b1, 12'd3601, 2'd0);
        pulses(1);
        cyc(1);        check("anim_f0", 1'b1, 12'd17, 2'd0);
        pulses(6);
        cyc(1);        check("anim_f1", 1'b1, 12'd529, 2'd0);
        pulses(5);
        cyc(1);        check("anim_hold_f1", 1'b1, 12'd529, 2'd0);
        pulses(1);
        cyc(1);        check("anim_wrap_f6", 1'b1, 12'd3089, 2'd0);

        pulses(6);
        cyc(1);        check("anim_en_f7", 1'b1, 12'd3601, 2'd0);
        anim_en_in[0] = 1'b0;
        cyc(2);        check("anim_off_f6", 1'b1, 12'd3089, 2'd0);
        anim_en_in[0] = 1'b1;

        // Reach phase 2 (frame 0), then reset mid-operation.
        pulses(12);
        cyc(1);        check("pre_reset_f0", 1'b1, 12'd17, 2'd0);
        rst = 1'b1;
        cyc(1);        check("reset_mid", 1'b0, 12'd0, 2'd0);
        rst = 1'b0;
        cyc(1);        check("reset_lat1", 1'b0, 12'd0, 2'd0);
        cyc(1);        check("reset_lat2_phase0", 1'b1, 12'd3089, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
